// File: rtl/execute_stage_if.sv
// Bus between the ID/EX register, the EX stage and the EX/MEM boundary.
// The slave modport is the execute stage; the master modport is its environment.
interface execute_stage_if;
  logic [31:0] d1_in;
  logic [31:0] d2_in;
  logic [4:0]  rd_in;
  logic [15:0] muxctrl_in;
  logic [2:0]  memctrl_in;
  logic [3:0]  aluctrl_in;
  logic [31:0] result_out;
  logic [31:0] d2_out;
  logic [4:0]  rd_out;
  logic [15:0] muxctrl_out;
  logic [2:0]  memctrl_out;
  logic        busy_out;
  logic        stall_out;

  modport slave (
    input  d1_in, d2_in, rd_in, muxctrl_in, memctrl_in, aluctrl_in,
    output result_out, d2_out, rd_out, muxctrl_out, memctrl_out, busy_out, stall_out
  );

  modport master (
    output d1_in, d2_in, rd_in, muxctrl_in, memctrl_in, aluctrl_in,
    input  result_out, d2_out, rd_out, muxctrl_out, memctrl_out, busy_out, stall_out
  );
endinterface

// File: rtl/execute_stage.sv
// MIPS EX stage: single-cycle ALU, iterative multiply/divide with HI/LO,
// registered EX/MEM outputs and a stall when the mult/div unit is busy.
module execute_stage #(
  parameter int unsigned MD_CYCLES = 32
) (
  input logic           clock,
  input logic           reset,
  execute_stage_if.slave ex
);
  localparam int unsigned CntW = $clog2(MD_CYCLES + 1);

  logic [31:0]   result_q, result_d, d2_q, d2_d;
  logic [4:0]    rd_q, rd_d;
  logic [15:0]   muxctrl_q, muxctrl_d;
  logic [2:0]    memctrl_q, memctrl_d;
  logic          busy_q, busy_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
  logic [64:0]   acc_q, acc_d;
  logic [31:0]   b_q, b_d, a_q, a_d;
  logic          is_div_q, is_div_d, neg_lo_q, neg_lo_d, neg_hi_q, neg_hi_d;
  logic          div0_q, div0_d;

  logic          is_md, stall, issue, md_signed, md_div;
  logic [31:0]   alu_res, abs_a, abs_b;
  logic [32:0]   mul_upper, rem_sh;
  logic [33:0]   diff;
  logic          ge;
  logic [64:0]   step;
  logic [63:0]   prod;
  logic [31:0]   fin_hi, fin_lo;

  assign is_md     = (ex.aluctrl_in[3:2] == 2'b11);
  assign stall     = busy_q & (ex.muxctrl_in[1] | ex.muxctrl_in[2] | is_md);
  assign issue     = is_md & ~stall;
  assign md_signed = ~ex.aluctrl_in[0];
  assign md_div    = ex.aluctrl_in[1];
  assign abs_a     = (md_signed && ex.d1_in[31]) ? (32'd0 - ex.d1_in) : ex.d1_in;
  assign abs_b     = (md_signed && ex.d2_in[31]) ? (32'd0 - ex.d2_in) : ex.d2_in;

  always_comb begin
    alu_res = '0;
    case (ex.aluctrl_in)
      4'd0:  alu_res = ex.d1_in + ex.d2_in;
      4'd1:  alu_res = ex.d1_in - ex.d2_in;
      4'd2:  alu_res = ex.d1_in & ex.d2_in;
      4'd3:  alu_res = ex.d1_in | ex.d2_in;
      4'd4:  alu_res = ex.d1_in ^ ex.d2_in;
      4'd5:  alu_res = ~(ex.d1_in | ex.d2_in);
      4'd6:  alu_res = {31'd0, $signed(ex.d1_in) < $signed(ex.d2_in)};
      4'd7:  alu_res = {31'd0, ex.d1_in < ex.d2_in};
      4'd8:  alu_res = ex.d2_in << ex.d1_in[4:0];
      4'd9:  alu_res = ex.d2_in >> ex.d1_in[4:0];
      4'd10: alu_res = $unsigned($signed(ex.d2_in) >>> ex.d1_in[4:0]);
      4'd11: alu_res = {ex.d2_in[15:0], 16'h0000};
      default: alu_res = '0;
    endcase
  end

  // One iteration of shift-add multiply or restoring divide.
  always_comb begin
    mul_upper = acc_q[64:32] + (acc_q[0] ? {1'b0, b_q} : 33'd0);
    rem_sh    = {acc_q[63:32], acc_q[31]};
    diff      = {1'b0, rem_sh} - {2'b00, b_q};
    ge        = ~diff[33];
    if (is_div_q) step = {(ge ? diff[32:0] : rem_sh), acc_q[30:0], ge};
    else          step = {1'b0, mul_upper, acc_q[31:1]};
    prod   = neg_lo_q ? (64'd0 - step[63:0]) : step[63:0];
    fin_hi = prod[63:32];
    fin_lo = prod[31:0];
    if (is_div_q) begin
      if (div0_q) begin
        fin_lo = 32'hFFFF_FFFF;
        fin_hi = a_q;
      end else begin
        fin_lo = neg_lo_q ? (32'd0 - step[31:0])  : step[31:0];
        fin_hi = neg_hi_q ? (32'd0 - step[63:32]) : step[63:32];
      end
    end
  end

  always_comb begin
    result_d  = '0;
    d2_d      = '0;
    rd_d      = '0;
    muxctrl_d = '0;
    memctrl_d = '0;
    busy_d    = busy_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    acc_d     = acc_q;
    b_d       = b_q;
    a_d       = a_q;
    is_div_d  = is_div_q;
    neg_lo_d  = neg_lo_q;
    neg_hi_d  = neg_hi_q;
    div0_d    = div0_q;

    if (!stall) begin
      d2_d      = ex.d2_in;
      rd_d      = ex.rd_in;
      muxctrl_d = ex.muxctrl_in;
      memctrl_d = ex.memctrl_in;
      if (issue)                 result_d = '0;
      else if (ex.muxctrl_in[1]) result_d = hi_q;
      else if (ex.muxctrl_in[2]) result_d = lo_q;
      else                       result_d = alu_res;
      if (issue) muxctrl_d[3] = 1'b0;
    end

    if (busy_q) begin
      acc_d = step;
      cnt_d = cnt_q - CntW'(1);
      if (cnt_q == CntW'(1)) begin
        busy_d = 1'b0;
        hi_d   = fin_hi;
        lo_d   = fin_lo;
      end
    end else if (issue) begin
      busy_d   = 1'b1;
      cnt_d    = CntW'(MD_CYCLES);
      acc_d    = {33'd0, abs_a};
      b_d      = abs_b;
      a_d      = ex.d1_in;
      is_div_d = md_div;
      neg_lo_d = md_signed & (ex.d1_in[31] ^ ex.d2_in[31]);
      neg_hi_d = md_signed & (md_div ? ex.d1_in[31] : (ex.d1_in[31] ^ ex.d2_in[31]));
      div0_d   = md_div & (ex.d2_in == 32'd0);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      result_q  <= '0;
      d2_q      <= '0;
      rd_q      <= '0;
      muxctrl_q <= '0;
      memctrl_q <= '0;
      busy_q    <= 1'b0;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      acc_q     <= '0;
      b_q       <= '0;
      a_q       <= '0;
      is_div_q  <= 1'b0;
      neg_lo_q  <= 1'b0;
      neg_hi_q  <= 1'b0;
      div0_q    <= 1'b0;
    end else begin
      result_q  <= result_d;
      d2_q      <= d2_d;
      rd_q      <= rd_d;
      muxctrl_q <= muxctrl_d;
      memctrl_q <= memctrl_d;
      busy_q    <= busy_d;
      cnt_q     <= cnt_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      acc_q     <= acc_d;
      b_q       <= b_d;
      a_q       <= a_d;
      is_div_q  <= is_div_d;
      neg_lo_q  <= neg_lo_d;
      neg_hi_q  <= neg_hi_d;
      div0_q    <= div0_d;
    end
  end

  assign ex.result_out  = result_q;
  assign ex.d2_out      = d2_q;
  assign ex.rd_out      = rd_q;
  assign ex.muxctrl_out = muxctrl_q;
  assign ex.memctrl_out = memctrl_q;
  assign ex.busy_out    = busy_q;
  assign ex.stall_out   = stall;
endmodule
